ps2_frame_shifter: RTL and testbench
====================================

# ps2_frame_shifter

Parametrised successor to the PS/2 input shift register. It is a WIDTH-bit universal shift register with hold, right-shift, left-shift and parallel load. An optional frame mode deserialises one PS/2 device frame: start, WIDTH data bits LSB-first, odd parity, stop. It sits between the PS/2 clock-edge sampler (which drives `en`/`d`) and the keyboard scan-code decoder.

## Interface
- `WIDTH`, 8, data/register width in bits (≥2)
- `clk`  in  1  system clock, rising-edge active
- `reset`  in  1  asynchronous, active-low (0 = reset)
- `en`  in  1  operation strobe; no state changes when 0
- `mode`  in  2  00 hold, 01 shift right (d→MSB), 10 shift left (d→LSB), 11 parallel load
- `d`  in  1  serial input bit
- `load_data`  in  WIDTH  parallel load value
- `frame_mode`  in  1  1 = PS/2 framing FSM active
- `q`  out  WIDTH  register contents
- `so`  out  1  bit shifted out by the most recent shift (registered)
- `data_out`  out  WIDTH  last valid frame payload
- `frame_valid`  out  1  one-cycle pulse, good frame
- `frame_err`  out  1  one-cycle pulse, bad frame
- `busy`  out  1  frame FSM not in IDLE

## Operation
- Reset (async, `reset`=0): `q`=0, `so`=0, `data_out`=0, `frame_valid`=0, `frame_err`=0, `busy`=0, FSM=IDLE, bit count=0.
- Register op occurs only on edges with `en`=1. Right shift: `q`←{d, q[WIDTH-1:1]}, `so`←q[0]. Left shift: `q`←{q[WIDTH-2:0], d}, `so`←q[WIDTH-1]. Load: `q`←`load_data`, `so` unchanged. Hold: nothing changes.
- Frame FSM advances only on `en`=1 with `frame_mode`=1 and `mode`=01. States:
  - IDLE: `d`=0 (start) → DATA with count=0. `q` is not shifted on the start bit. `d`=1 → stay in IDLE.
  - DATA: shift right; count+1; after the WIDTH-th data bit → PARITY.
  - PARITY: latch `d` as parity bit, no shift → STOP.
  - STOP: on the stop sample → IDLE. Good frame requires `d`=1 and odd parity (XOR of `q`^parity = 1). Good frame: `data_out`←`q`, pulse `frame_valid`. Bad frame: pulse `frame_err`, `data_out` unchanged.
- Abort: while not in IDLE, `frame_mode`=0, or `en`=1 with `mode`≠01, forces IDLE with no pulse. `q` keeps its value, and any `mode` operation on that edge is still applied.
- `frame_valid` and `frame_err` are never high together. Each is high for exactly one cycle.
- With `frame_mode`=0 the block is a plain universal shift register. The FSM stays in IDLE.

## Timing
- `q` and `so` update on the same edge that samples `en`. Latency is 1 cycle.
- `frame_valid`/`frame_err` go high on the edge that samples the stop bit and clear on the next edge.
- A full frame needs WIDTH+3 `en` strobes. `busy` rises on the start-bit edge and falls on the stop-bit edge.
- Back-to-back frames: a start bit may be sampled on the strobe immediately after stop.
- Reset asserted mid-frame clears everything immediately. Frame reception resumes only on a new start bit after reset is released.

## Configuration
- `PS2_PARITY_CHECK_EN` defined: parity mismatch produces `frame_err`.
- Not defined: the parity bit is sampled and discarded. Only the stop bit decides good/bad. Everything else is identical.

## Structure
- Shared package `ps2_pkg`: mode encodings (`MODE_HOLD`, `MODE_SHR`, `MODE_SHL`, `MODE_LOAD`) and FSM state typedef (IDLE, DATA, PARITY, STOP).
- One sub-module, `ps2_frame_fsm`: holds state, bit counter, parity and the pulse outputs. The top holds the shift datapath and `data_out`.

## Test plan
- Parallel load 0xA5, then `mode`=01, `d`=1, one strobe → `q`=0xD2, `so`=1. Then `mode`=10, `d`=0 → `q`=0xA4, `so`=1.
- Frame 0x5A (bits 0, 0,1,0,1,1,0,1,0, 1, 1) → single `frame_valid` pulse on the stop edge, `data_out`=0x5A, `busy` high for 10 strobes.
- Same frame with parity 0 → `frame_err` pulse, `data_out` unchanged. Without `PS2_PARITY_CHECK_EN` → `frame_valid`, `data_out`=0x5A.
- Frame 0x5A with stop 0 → `frame_err` pulse regardless of macro.
- Reset low after 4 data bits → all outputs 0 immediately. A following full frame 0x12 → `frame_valid`, `data_out`=0x12.
- `en`=0 for 20 cycles mid-frame → no change in `q` or state. The frame completes correctly when the strobes resume.

Source files
------------

// File: rtl/ps2_pkg.sv
// Shared encodings for the PS/2 frame shifter: register-op modes and frame FSM states.
// Combinational definitions only; no latency, no backpressure.
package ps2_pkg;

    typedef enum logic [1:0] {
        MODE_HOLD = 2'b00,
        MODE_SHR  = 2'b01,
        MODE_SHL  = 2'b10,
        MODE_LOAD = 2'b11
    } mode_e;

    typedef enum logic [1:0] {
        IDLE   = 2'b00,
        DATA   = 2'b01,
        PARITY = 2'b10,
        STOP   = 2'b11
    } frame_state_e;

    // Data-bit counter width; a 1-bit counter is still needed when WIDTH is 2.
    function automatic int cnt_width(input int width);
        return (width <= 2) ? 1 : $clog2(width);
    endfunction

endpackage

// File: rtl/ps2_frame_shifter_if.sv
// Bundles the shifter's strobe/mode/data inputs and register/frame outputs.
// The master side is the PS/2 edge sampler; the slave side is the shifter itself.
interface ps2_frame_shifter_if #(parameter int WIDTH = 8);
    import ps2_pkg::*;

    logic             en;
    mode_e            mode;
    logic             d;
    logic [WIDTH-1:0] load_data;
    logic             frame_mode;
    logic [WIDTH-1:0] q;
    logic             so;
    logic [WIDTH-1:0] data_out;
    logic             frame_valid;
    logic             frame_err;
    logic             busy;

    modport master (
        output en, mode, d, load_data, frame_mode,
        input  q, so, data_out, frame_valid, frame_err, busy
    );

    modport slave (
        input  en, mode, d, load_data, frame_mode,
        output q, so, data_out, frame_valid, frame_err, busy
    );

endinterface

// File: rtl/ps2_frame_fsm.sv
// PS/2 frame sequencer (start, data LSB-first, parity, stop); pulses registered, 1-cycle latency.
// Advances only on en strobes; PS2_PARITY_CHECK_EN makes an even-parity frame an error.
module ps2_frame_fsm
    import ps2_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic  clk,
    input  logic  reset,
    input  logic  en_i,
    input  mode_e mode_i,
    input  logic  frame_mode_i,
    input  logic  d_i,
    output logic  shr_allow_o,
    output logic  capture_o,
    output logic  busy_o,
    output logic  frame_valid_o,
    output logic  frame_err_o
);

    localparam int CW = cnt_width(WIDTH);
    localparam logic [CW-1:0] LAST_BIT = CW'(WIDTH - 1);

    frame_state_e  state_q;
    logic [CW-1:0] cnt_q;
    logic          busy_q;
    logic          valid_q;
    logic          err_q;
    logic          step;
    logic          abort;
    logic          good;

`ifdef PS2_PARITY_CHECK_EN
    logic          par_q;
    assign good = d_i & par_q;
`else
    assign good = d_i;
`endif

    assign step  = en_i & frame_mode_i & (mode_i == MODE_SHR);
    assign abort = (state_q != IDLE) & (~frame_mode_i | (en_i & (mode_i != MODE_SHR)));

    // In frame mode only the data bits move through the shift register.
    assign shr_allow_o = ~frame_mode_i | (state_q == DATA);
    assign capture_o   = step & (state_q == STOP) & good;

    assign busy_o        = busy_q;
    assign frame_valid_o = valid_q;
    assign frame_err_o   = err_q;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            busy_q  <= 1'b0;
            valid_q <= 1'b0;
            err_q   <= 1'b0;
`ifdef PS2_PARITY_CHECK_EN
            par_q   <= 1'b0;
`endif
        end else begin
            valid_q <= 1'b0;
            err_q   <= 1'b0;
            if (abort) begin
                state_q <= IDLE;
                busy_q  <= 1'b0;
            end else if (step) begin
                unique case (state_q)
                    IDLE: begin
                        if (!d_i) begin
                            state_q <= DATA;
                            cnt_q   <= '0;
                            busy_q  <= 1'b1;
`ifdef PS2_PARITY_CHECK_EN
                            par_q   <= 1'b0;
`endif
                        end
                    end
                    DATA: begin
                        cnt_q <= cnt_q + 1'b1;
`ifdef PS2_PARITY_CHECK_EN
                        par_q <= par_q ^ d_i;
`endif
                        if (cnt_q == LAST_BIT) begin
                            state_q <= PARITY;
                        end
                    end
                    PARITY: begin
`ifdef PS2_PARITY_CHECK_EN
                        par_q <= par_q ^ d_i;
`endif
                        state_q <= STOP;
                    end
                    STOP: begin
                        state_q <= IDLE;
                        busy_q  <= 1'b0;
                        valid_q <= good;
                        err_q   <= ~good;
                    end
                endcase
            end
        end
    end

endmodule

// File: rtl/ps2_frame_shifter.sv
// WIDTH-bit universal shift register with optional PS/2 frame deserialisation; 1-cycle latency.
// Acts only on en strobes (no backpressure); PS2_PARITY_CHECK_EN enables parity rejection.
module ps2_frame_shifter
    import ps2_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic                clk,
    input  logic                reset,
    ps2_frame_shifter_if.slave  bus
);

    logic [WIDTH-1:0] q_q, q_d;
    logic             so_q, so_d;
    logic [WIDTH-1:0] data_out_q, data_out_d;
    logic             shr_allow;
    logic             capture;
    logic             busy;
    logic             frame_valid;
    logic             frame_err;

    ps2_frame_fsm #(.WIDTH(WIDTH)) u_fsm (
        .clk           (clk),
        .reset         (reset),
        .en_i          (bus.en),
        .mode_i        (bus.mode),
        .frame_mode_i  (bus.frame_mode),
        .d_i           (bus.d),
        .shr_allow_o   (shr_allow),
        .capture_o     (capture),
        .busy_o        (busy),
        .frame_valid_o (frame_valid),
        .frame_err_o   (frame_err)
    );

    always_comb begin
        q_d        = q_q;
        so_d       = so_q;
        data_out_d = data_out_q;
        if (bus.en) begin
            unique case (bus.mode)
                MODE_SHR: begin
                    if (shr_allow) begin
                        q_d  = {bus.d, q_q[WIDTH-1:1]};
                        so_d = q_q[0];
                    end
                end
                MODE_SHL: begin
                    q_d  = {q_q[WIDTH-2:0], bus.d};
                    so_d = q_q[WIDTH-1];
                end
                MODE_LOAD: q_d = bus.load_data;
                default:   ;
            endcase
        end
        // q is not shifted on the stop edge, so it still holds the payload here.
        if (capture) begin
            data_out_d = q_q;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            q_q        <= '0;
            so_q       <= 1'b0;
            data_out_q <= '0;
        end else begin
            q_q        <= q_d;
            so_q       <= so_d;
            data_out_q <= data_out_d;
        end
    end

    assign bus.q           = q_q;
    assign bus.so          = so_q;
    assign bus.data_out    = data_out_q;
    assign bus.frame_valid = frame_valid;
    assign bus.frame_err   = frame_err;
    assign bus.busy        = busy;

endmodule

// File: tb/tb_ps2_frame_shifter.sv
// Directed plus randomized bench for ps2_frame_shifter against a frame-level reference model.
module tb_ps2_frame_shifter;
    import ps2_pkg::*;

    localparam int W = 8;

    logic clk = 1'b0;
    logic reset = 1'b0;
    int   n_checks = 0;
    int   n_fail = 0;
    logic busy_before;
    logic [W-1:0] model_q;
    logic         model_so;
    logic [W-1:0] model_do;

    ps2_frame_shifter_if #(.WIDTH(W)) bus ();

    ps2_frame_shifter #(.WIDTH(W)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic idle(input int n);
        bus.en = 1'b0;
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic strobe(input mode_e m, input logic dd, input logic [W-1:0] ld);
        bus.mode      = m;
        bus.d         = dd;
        bus.load_data = ld;
        bus.en        = 1'b1;
        busy_before   = bus.busy;
        @(posedge clk);
        #1;
        bus.en = 1'b0;
    endtask

    function automatic logic odd_par(input logic [W-1:0] v);
        return ($countones(v) % 2) == 0;
    endfunction

    // Sends a whole frame; pause_at >= 0 inserts a 20-cycle strobe gap before that data bit.
    task automatic send_frame(input logic [W-1:0] data, input logic par, input logic stop,
                              input int pause_at, input logic holes);
        logic         good;
        int           busy_n;
        logic [W-1:0] q_snap;
        good = stop;
`ifdef PS2_PARITY_CHECK_EN
        good = stop && ((($countones(data) + par) % 2) == 1);
`endif
        bus.frame_mode = 1'b1;
        strobe(MODE_SHR, 1'b0, '0);
        check("start_busy", bus.busy, 1);
        check("start_no_valid", bus.frame_valid, 0);
        check("start_no_err", bus.frame_err, 0);
        busy_n = 0;
        for (int i = 0; i < W; i++) begin
            if (i == pause_at) begin
                q_snap = bus.q;
                idle(20);
                check("pause_q", bus.q, q_snap);
                check("pause_busy", bus.busy, 1);
            end
            strobe(MODE_SHR, data[i], '0);
            busy_n += int'(busy_before);
            if (holes) idle($urandom_range(0, 2));
        end
        strobe(MODE_SHR, par, '0);
        busy_n += int'(busy_before);
        strobe(MODE_SHR, stop, '0);
        busy_n += int'(busy_before);
        if (good) model_do = data;
        check("stop_valid", bus.frame_valid, good);
        check("stop_err", bus.frame_err, !good);
        check("stop_busy", bus.busy, 0);
        check("stop_data_out", bus.data_out, model_do);
        check("frame_q", bus.q, data);
        check("busy_strobes", busy_n, W + 2);
    endtask

    initial begin
        logic [W-1:0] ld;
        logic         dd;
        logic         en_r;
        mode_e        m;
        logic [W-1:0] byte_r;
        logic         par_r;
        logic         stop_r;

        bus.en = 1'b0; bus.mode = MODE_HOLD; bus.d = 1'b1;
        bus.load_data = '0; bus.frame_mode = 1'b0;
        #1;
        check("rst_q", bus.q, 0);
        check("rst_so", bus.so, 0);
        check("rst_data_out", bus.data_out, 0);
        check("rst_valid", bus.frame_valid, 0);
        check("rst_err", bus.frame_err, 0);
        check("rst_busy", bus.busy, 0);
        repeat (2) @(posedge clk);
        #1 reset = 1'b1;

        // Directed register operations
        strobe(MODE_LOAD, 1'b0, 8'hA5);
        check("load_q", bus.q, 8'hA5);
        check("load_so", bus.so, 0);
        strobe(MODE_SHR, 1'b1, '0);
        check("shr_q", bus.q, 8'hD2);
        check("shr_so", bus.so, 1);
        strobe(MODE_SHL, 1'b0, '0);
        check("shl_q", bus.q, 8'hA4);
        check("shl_so", bus.so, 1);
        strobe(MODE_HOLD, 1'b1, 8'hFF);
        check("hold_q", bus.q, 8'hA4);
        bus.mode = MODE_LOAD; bus.load_data = 8'h00; idle(3);
        check("en_low_q", bus.q, 8'hA4);

        // Randomized plain shift-register operation
        model_q = 8'hA4; model_so = 1'b1;
        for (int i = 0; i < 300; i++) begin
            en_r = 1'($urandom_range(0, 3) != 0);
            m    = mode_e'($urandom_range(0, 3));
            dd   = 1'($urandom_range(0, 1));
            ld   = W'($urandom);
            bus.mode = m; bus.d = dd; bus.load_data = ld; bus.en = en_r;
            @(posedge clk);
            #1;
            bus.en = 1'b0;
            if (en_r) begin
                case (m)
                    MODE_SHR: begin
                        model_so = model_q[0];
                        model_q  = (model_q >> 1) + (W'(dd) << (W - 1));
                    end
                    MODE_SHL: begin
                        model_so = model_q[W-1];
                        model_q  = W'((32'(model_q) * 2) % (1 << W)) + W'(dd);
                    end
                    MODE_LOAD: model_q = ld;
                    default: ;
                endcase
            end
            check("rnd_q", bus.q, model_q);
            check("rnd_so", bus.so, model_so);
            check("rnd_busy", bus.busy, 0);
        end

        // Directed frames
        model_do = 8'h00;
        send_frame(8'h5A, 1'b1, 1'b1, -1, 1'b0);
        idle(1);
        check("pulse_clear_valid", bus.frame_valid, 0);
        check("pulse_clear_err", bus.frame_err, 0);
        send_frame(8'h33, 1'b1, 1'b1, -1, 1'b0);
        send_frame(8'h5A, 1'b0, 1'b1, -1, 1'b0);
        idle(1);
        send_frame(8'h33, 1'b1, 1'b1, -1, 1'b0);
        send_frame(8'h5A, 1'b1, 1'b0, -1, 1'b0);
        check("bad_stop_keeps", bus.data_out, 8'h33);
        idle(1);

        // Reset mid-frame, then recover
        bus.frame_mode = 1'b1;
        strobe(MODE_SHR, 1'b0, '0);
        for (int i = 0; i < 4; i++) strobe(MODE_SHR, 1'($urandom_range(0, 1)), '0);
        reset = 1'b0;
        #1;
        check("mid_rst_q", bus.q, 0);
        check("mid_rst_so", bus.so, 0);
        check("mid_rst_data_out", bus.data_out, 0);
        check("mid_rst_busy", bus.busy, 0);
        check("mid_rst_valid", bus.frame_valid, 0);
        model_do = 8'h00;
        @(posedge clk);
        #1 reset = 1'b1;
        strobe(MODE_SHR, 1'b1, '0);
        check("post_rst_idle", bus.busy, 0);
        send_frame(8'h12, 1'b1, 1'b1, -1, 1'b0);
        check("post_rst_data", bus.data_out, 8'h12);

        // Strobe gap mid-frame
        send_frame(8'hC4, odd_par(8'hC4), 1'b1, 3, 1'b0);

        // Abort by a load mid-frame
        strobe(MODE_SHR, 1'b0, '0);
        for (int i = 0; i < 3; i++) strobe(MODE_SHR, 1'b1, '0);
        strobe(MODE_LOAD, 1'b0, 8'h3C);
        check("abort_busy", bus.busy, 0);
        check("abort_q", bus.q, 8'h3C);
        check("abort_valid", bus.frame_valid, 0);
        check("abort_err", bus.frame_err, 0);
        // Abort by leaving frame mode
        strobe(MODE_SHR, 1'b0, '0);
        strobe(MODE_SHR, 1'b1, '0);
        bus.frame_mode = 1'b0;
        idle(1);
        check("fm_abort_busy", bus.busy, 0);
        check("fm_abort_data_out", bus.data_out, model_do);

        // Randomized frames, some back-to-back, some with strobe holes
        for (int f = 0; f < 25; f++) begin
            byte_r = W'($urandom);
            par_r  = ($urandom_range(0, 3) == 0) ? !odd_par(byte_r) : odd_par(byte_r);
            stop_r = 1'($urandom_range(0, 4) != 0);
            send_frame(byte_r, par_r, stop_r, -1, 1'($urandom_range(0, 1)));
            if ($urandom_range(0, 1) == 1) idle($urandom_range(1, 3));
        end
        idle(1);
        check("final_valid", bus.frame_valid, 0);
        check("final_err", bus.frame_err, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
